// File: rtl/rate_counter_hex.sv
// rate_counter_hex: rate-divided hex counter with 7-seg outputs; RATE_COUNTER_BCD_EN selects decimal digits
module rate_counter_hex #(
  parameter int DIGITS    = 2,
  parameter int RATE_BASE = 50000000,
  parameter int RATE_W    = 28
) (
  input  logic                  CLOCK_50,
  input  logic                  clear_b,
  input  logic [1:0]            mode,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   HEX
);
  localparam int W = 4*DIGITS;
  localparam logic [15:0][6:0] SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  logic [RATE_W-1:0] div;
  logic [1:0]        mode_q;
  logic [W-1:0]      step_val;
  logic [W-1:0]      load_fix;
  logic              step_wrap;
  function automatic logic [RATE_W-1:0] term(input logic [1:0] m);
    return m == 2'd0 ? '0 : RATE_W'((RATE_BASE << (m - 2'd1)) - 1);
  endfunction
  always_ff @(posedge CLOCK_50) begin
    if (clear_b) begin
      div    <= term(mode);
      mode_q <= mode;
      tick   <= 1'b0;
      count  <= '0;
      wrap   <= 1'b0;
    end else begin
      mode_q <= mode;
      div    <= (mode != mode_q || div == '0) ? term(mode) : div - RATE_W'(1);
      tick   <= mode == mode_q && div == '0;
      count  <= load ? load_fix : (tick & enable) ? step_val : count;
      wrap   <= !load & tick & enable & step_wrap;
    end
  end
`ifdef RATE_COUNTER_BCD_EN
  // c[k] is the carry/borrow into digit k; c[DIGITS] set means every digit rolled over
  logic [DIGITS:0] c;
  assign c[0] = 1'b1;
  for (genvar k = 0; k < DIGITS; k++) begin : g_bcd
    logic [3:0] d;
    logic [3:0] lv;
    assign d  = count[4*k +: 4];
    assign lv = load_val[4*k +: 4];
    assign step_val[4*k +: 4] = !c[k] ? d :
                                up ? (d == 4'd9 ? 4'd0 : d + 4'd1) :
                                     (d == 4'd0 ? 4'd9 : d - 4'd1);
    assign c[k+1] = c[k] & (up ? d == 4'd9 : d == 4'd0);
    assign load_fix[4*k +: 4] = lv > 4'd9 ? 4'd0 : lv;
  end
  assign step_wrap = c[DIGITS];
`else
  assign step_val  = count + {{(W-1){~up}}, 1'b1};
  assign step_wrap = up ? &count : ~|count;
  assign load_fix  = load_val;
`endif
  for (genvar k = 0; k < DIGITS; k++) begin : g_hex
    assign HEX[7*k +: 7] = SEG[count[4*k +: 4]];
  end
endmodule

// File: tb/tb_rate_counter_hex.sv
// tb_rate_counter_hex: randomized check of rate_counter_hex against a cycle-count reference model
module tb_rate_counter_hex;
  localparam int DIGITS = 2;
  localparam int RB     = 4;
`ifdef RATE_COUNTER_BCD_EN
  localparam int B = 10;
`else
  localparam int B = 16;
`endif
  localparam int N = B ** DIGITS;
  logic       CLOCK_50 = 1'b0;
  logic       clear_b  = 1'b1;
  logic [1:0] mode     = 2'd1;
  logic       enable   = 1'b1;
  logic       up       = 1'b1;
  logic       load     = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       tick;
  logic [7:0] count;
  logic       wrap;
  logic [13:0] HEX;
  int checks = 0, failures = 0;
  int since, m_count;
  logic [1:0] m_mode;
  bit m_tick, m_wrap;
  string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
  rate_counter_hex #(.DIGITS(DIGITS), .RATE_BASE(RB), .RATE_W(8)) dut (
    .CLOCK_50(CLOCK_50), .clear_b(clear_b), .mode(mode), .enable(enable), .up(up),
    .load(load), .load_val(load_val), .tick(tick), .count(count), .wrap(wrap), .HEX(HEX)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  function automatic int period(input logic [1:0] m);
    return m == 2'd0 ? 1 : RB << (m - 1);
  endfunction
  function automatic logic [7:0] to_bits(input int v);
    logic [7:0] r;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / (B ** k)) % B);
    return r;
  endfunction
  function automatic int from_load(input logic [7:0] lv);
    int s = 0;
    for (int k = 0; k < DIGITS; k++) s += (int'(lv[4*k +: 4]) >= B ? 0 : int'(lv[4*k +: 4])) * (B ** k);
    return s;
  endfunction
  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] r = 7'h7F;
    string s = glyph[d];
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    return r;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge CLOCK_50);
    if (clear_b) begin
      since = 0; m_mode = mode; m_tick = 0; m_count = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (load) m_count = from_load(load_val);
      else if (m_tick && enable) begin
        if (up) begin m_wrap = m_count == N - 1; m_count = (m_count + 1) % N; end
        else begin m_wrap = m_count == 0; m_count = (m_count + N - 1) % N; end
      end
      if (mode != m_mode) begin
        m_mode = mode; since = 0; m_tick = 0;
      end else begin
        since++;
        m_tick = since == period(mode);
        if (m_tick) since = 0;
      end
    end
    #1;
    check("tick", 32'(tick), 32'(m_tick));
    check("count", 32'(count), 32'(to_bits(m_count)));
    check("wrap", 32'(wrap), 32'(m_wrap));
    for (int k = 0; k < DIGITS; k++) check("hex", 32'(HEX[7*k +: 7]), 32'(seg(to_bits(m_count)[4*k +: 4])));
  endtask
  initial begin
    step();
    check("rst_count", 32'(count), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    clear_b = 1'b0;
    repeat (4) step();
    check("cnt_c4", 32'(count), 32'h0);
    step();
    check("cnt_c5", 32'(count), 32'h1);
    check("hex_one", 32'(HEX[6:0]), 32'h79);
    check("hex_zero", 32'(HEX[13:7]), 32'h40);
    repeat (4) step();
    check("cnt_c9", 32'(count), 32'h2);
    mode = 2'd0;
    step();
    check("mode_chg_notick", 32'(tick), 32'h0);
`ifdef RATE_COUNTER_BCD_EN
    load = 1'b1; load_val = 8'h99; step();
    load = 1'b0; step();
    check("bcd_wrap_cnt", 32'(count), 32'h00);
    check("bcd_wrap", 32'(wrap), 32'h1);
    load = 1'b1; load_val = 8'hA7; step();
    load = 1'b0;
    check("bcd_load_fix", 32'(count), 32'h07);
`else
    load = 1'b1; load_val = 8'hFE; step();
    load = 1'b0;
    check("ld_fe", 32'(count), 32'hFE);
    step();
    check("cnt_ff", 32'(count), 32'hFF);
    check("wrap_ff", 32'(wrap), 32'h0);
    step();
    check("cnt_00", 32'(count), 32'h00);
    check("wrap_up", 32'(wrap), 32'h1);
    up = 1'b0; step();
    check("cnt_dn_ff", 32'(count), 32'hFF);
    check("wrap_dn", 32'(wrap), 32'h1);
    up = 1'b1; load = 1'b1; load_val = 8'h3C; step();
    check("ld_tick_cnt", 32'(count), 32'h3C);
    check("ld_tick_wrap", 32'(wrap), 32'h0);
    load = 1'b0; enable = 1'b0;
    repeat (3) step();
    check("hold_3c", 32'(count), 32'h3C);
    enable = 1'b1;
`endif
    mode = 2'd1; load = 1'b1; load_val = 8'h55; step();
    load = 1'b0;
    repeat (2) step();
    clear_b = 1'b1; step();
    check("clr_count", 32'(count), 32'h0);
    check("clr_wrap", 32'(wrap), 32'h0);
    clear_b = 1'b0;
    repeat (3) step();
    check("clr_notick", 32'(tick), 32'h0);
    step();
    check("clr_tick", 32'(tick), 32'h1);
    repeat (3000) begin
      clear_b  = $urandom_range(199) == 0;
      if ($urandom_range(79) == 0) mode = 2'($urandom);
      load     = $urandom_range(29) == 0;
      load_val = 8'($urandom);
      enable   = $urandom_range(7) != 0;
      if ($urandom_range(19) == 0) up = ~up;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
